pot_spi_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single potentiometer SPI master (the rst/sclk/din bus to the comparator and op-amp potentiometers) between four register-writing requesters. Each requester owns one chip-select line: sync_cmp_a, sync_cmp_b, sync_oa_0 and sync_oa_1. The block sits between the UART packet decoder's per-address write ports and the SPI master. It grants one requester at a time, drives that requester's active-low sync line for the whole transfer, enforces an inter-frame gap, and aborts hung transfers.

---
 rtl/pot_spi_arbiter.sv | 151 +++++++++++++++
 tb/tb_pot_spi_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one potentiometer SPI master among N_REQ sync-line owners.
// Latency: grant visible one cycle after req_valid is sampled in IDLE; release one cycle after m_done.
// Backpressure: m_valid/m_data held steady until m_ready; requesters hold req_valid until req_ready.
module pot_spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int GAP_CYC = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk_100,
    input  logic                n_rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    req_done,
    output logic [N_REQ-1:0]    req_err,
    output logic                m_valid,
    output logic [DW-1:0]       m_data,
    input  logic                m_ready,
    input  logic                m_done,
    output logic [N_REQ-1:0]    sync_n,
    output logic                busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state;
    logic [IW-1:0]    last_grant;
    logic [TW-1:0]    to_cnt;
    logic [GW-1:0]    gap_cnt;

    logic             gnt_any;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    cand_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic [N_REQ-1:0] cur_oh;
    logic [DW-1:0]    gnt_dat;

    // Round-robin pick: scan last_grant+1 .. last_grant+N_REQ, lowest distance wins
    // (loop runs backwards so the nearest candidate is the final assignment).
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_idx = IW'((int'(last_grant) + k) % N_REQ);
            if (req_valid[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    // One-hot of the candidate, one-hot of the current owner, and the candidate's word.
    always_comb begin
        gnt_oh              = '0;
        gnt_oh[gnt_idx]     = 1'b1;
        cur_oh              = '0;
        cur_oh[last_grant]  = 1'b1;
        gnt_dat             = req_data[gnt_idx*DW +: DW];
    end

    // Sequencer: grant, offer word, hold chip select through the frame, then enforce the gap.
    always_ff @(posedge clk_100 or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            last_grant <= LAST_INIT;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            req_ready  <= '0;
            req_done   <= '0;
            req_err    <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            sync_n     <= '1;
            busy       <= 1'b0;
        end else begin
            // Status strobes are single-cycle unless re-armed below.
            req_ready <= '0;
            req_done  <= '0;
            req_err   <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        last_grant <= gnt_idx;
                        m_data     <= gnt_dat;
                        m_valid    <= 1'b1;
                        sync_n     <= ~gnt_oh;
                        req_ready  <= gnt_oh;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // m_valid is always high here, so m_ready alone completes the handshake.
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        to_cnt  <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion in the same cycle as the deadline counts as success.
                    if (m_done || (to_cnt == TO_LAST)) begin
                        if (m_done) begin
                            req_done <= cur_oh;
                        end else begin
                            req_err <= cur_oh;
                        end
                        sync_n  <= '1;
                        gap_cnt <= '0;
                        if (GAP_CYC == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // Stray m_done from an aborted frame lands here or in IDLE and is ignored.
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pot_spi_arbiter.sv
// Directed bench for pot_spi_arbiter: main instance (GAP_CYC=8, TIMEOUT=64) and a GAP_CYC=0 instance.
// Inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Expected values are hand-derived constants.
module tb_pot_spi_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;

    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [15:0] word [4];
    logic        m_ready, m_done;
    logic [3:0]  req_ready, req_done, req_err, sync_n;
    logic        m_valid, busy;
    logic [15:0] m_data;

    logic [3:0]  z_valid;
    logic [63:0] z_data;
    logic        z_m_ready, z_m_done;
    logic [3:0]  z_ready, z_done, z_err, z_sync_n;
    logic        z_m_valid, z_busy;
    logic [15:0] z_m_data;

    int n_checks = 0;
    int n_err    = 0;

    assign req_data = {word[3], word[2], word[1], word[0]};

    pot_spi_arbiter #(.N_REQ(4), .DW(16), .GAP_CYC(8), .TIMEOUT(64)) u_dut (
        .clk_100   (clk),
        .n_rst     (n_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_done  (req_done),
        .req_err   (req_err),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .m_done    (m_done),
        .sync_n    (sync_n),
        .busy      (busy)
    );

    pot_spi_arbiter #(.N_REQ(4), .DW(16), .GAP_CYC(0), .TIMEOUT(64)) u_dut_nogap (
        .clk_100   (clk),
        .n_rst     (n_rst),
        .req_valid (z_valid),
        .req_data  (z_data),
        .req_ready (z_ready),
        .req_done  (z_done),
        .req_err   (z_err),
        .m_valid   (z_m_valid),
        .m_data    (z_m_data),
        .m_ready   (z_m_ready),
        .m_done    (z_m_done),
        .sync_n    (z_sync_n),
        .busy      (z_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for requester g's frame to start, checks it, accepts it, completes it.
    task automatic run_frame(input int g, input string tag);
        logic [3:0] oh;
        logic [3:0] exp_s;
        int n;
        oh    = 4'b0001 << g;
        exp_s = ~oh;
        n     = 0;
        while (sync_n === 4'hF && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_sync"}, sync_n, exp_s);
        chk({tag, "_rdy"}, req_ready, oh);
        chk({tag, "_dat"}, m_data, word[g]);
        tick();
        chk({tag, "_mv"}, m_valid, 1'b0);
        chk({tag, "_hold"}, sync_n, exp_s);
        repeat (3) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk({tag, "_done"}, req_done, oh);
        chk({tag, "_rel"}, sync_n, 4'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_rst     = 1'b0;
        req_valid = '0;
        m_ready   = 1'b0;
        m_done    = 1'b0;
        for (int i = 0; i < 4; i++) word[i] = '0;
        z_valid   = '0;
        z_data    = '0;
        z_m_ready = 1'b0;
        z_m_done  = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_sync", sync_n, 4'hF);
        chk("rst_mv", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", req_ready, 4'h0);
        chk("rst_done", req_done, 4'h0);
        chk("rst_err", req_err, 4'h0);
        chk("rst_mdat", m_data, 16'h0);
        chk("rst_z_sync", z_sync_n, 4'hF);
        n_rst = 1'b1;
        tick();

        // Single request from requester 2, master ready immediately
        word[2]   = 16'hA050;
        req_valid = 4'b0100;
        m_ready   = 1'b1;
        tick();
        chk("single_rdy", req_ready, 4'b0100);
        chk("single_sync", sync_n, 4'b1011);
        chk("single_mv", m_valid, 1'b1);
        chk("single_dat", m_data, 16'hA050);
        chk("single_busy", busy, 1'b1);
        req_valid = '0;
        tick();
        chk("single_wait_mv", m_valid, 1'b0);
        chk("single_wait_rdy", req_ready, 4'h0);
        m_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            chk("single_frame_sync", sync_n, 4'b1011);
        end
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("single_done", req_done, 4'b0100);
        chk("single_rel", sync_n, 4'hF);
        chk("single_gap_busy", busy, 1'b1);

        // Same requester again: gap length, then master stalls 5 cycles
        word[2]   = 16'h1234;
        req_valid = 4'b0100;
        n = 0;
        while (sync_n === 4'hF && n < 40) begin
            tick();
            n++;
        end
        chk("gap_len", n, 9);
        chk("b2b_sync", sync_n, 4'b1011);
        chk("b2b_rdy", req_ready, 4'b0100);
        chk("b2b_dat", m_data, 16'h1234);
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_mv", m_valid, 1'b1);
            chk("stall_dat", m_data, 16'h1234);
            chk("stall_rdy", req_ready, 4'h0);
        end
        m_ready = 1'b1;
        tick();
        chk("stall_acc", m_valid, 1'b0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("stall_done", req_done, 4'b0100);

        // Round-robin from reset with all requesters pending
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        word[0] = 16'h1001;
        word[1] = 16'h2002;
        word[2] = 16'h3003;
        word[3] = 16'h4004;
        req_valid = 4'hF;
        for (int f = 0; f < 8; f++) run_frame(f % 4, "rr");

        // Fairness: last grant 3, then 0 and 1 alternate
        req_valid = 4'b0011;
        run_frame(0, "fair0");
        run_frame(1, "fair1");
        run_frame(0, "fair2");
        run_frame(1, "fair3");
        req_valid = '0;

        // Timeout: master accepts, never completes
        word[0]   = 16'hBEEF;
        req_valid = 4'b0001;
        n = 0;
        while (sync_n === 4'hF && n < 40) begin
            tick();
            n++;
        end
        chk("to_sync", sync_n, 4'b1110);
        req_valid = '0;
        tick();
        chk("to_acc", m_valid, 1'b0);
        n = 0;
        while (req_err === 4'h0 && n < 100) begin
            tick();
            n++;
        end
        chk("to_len", n, 64);
        chk("to_err", req_err, 4'b0001);
        chk("to_nodone", req_done, 4'h0);
        chk("to_rel", sync_n, 4'hF);
        repeat (5) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("stray_done", req_done, 4'h0);
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_idle", busy, 1'b0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("idle_stray_done", req_done, 4'h0);
        chk("idle_stray_sync", sync_n, 4'hF);

        // Asynchronous reset mid-frame, then requester 0 regains priority
        word[0]   = 16'h0C0C;
        req_valid = 4'b0001;
        n = 0;
        while (sync_n === 4'hF && n < 40) begin
            tick();
            n++;
        end
        req_valid = '0;
        tick();
        chk("mid_sync", sync_n, 4'b1110);
        chk("mid_mv", m_valid, 1'b0);
        tick();
        #1;
        n_rst = 1'b0;
        #1;
        chk("arst_sync", sync_n, 4'hF);
        chk("arst_mv", m_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_mdat", m_data, 16'h0);
        tick();
        n_rst = 1'b1;
        word[0] = 16'h5001;
        word[1] = 16'h5002;
        word[2] = 16'h5003;
        word[3] = 16'h5004;
        req_valid = 4'hF;
        run_frame(0, "post_rst");
        req_valid = '0;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("post_rst_idle", busy, 1'b0);

        // GAP_CYC=0 instance: delayed accept, immediate re-grant
        z_data[16 +: 16] = 16'h5A5A;
        z_data[0 +: 16]  = 16'h1111;
        z_valid = 4'b0010;
        tick();
        chk("z_sync", z_sync_n, 4'b1101);
        chk("z_rdy", z_ready, 4'b0010);
        chk("z_mv", z_m_valid, 1'b1);
        chk("z_dat", z_m_data, 16'h5A5A);
        z_valid = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("z_stall_mv", z_m_valid, 1'b1);
            chk("z_stall_dat", z_m_data, 16'h5A5A);
            chk("z_stall_sync", z_sync_n, 4'b1101);
        end
        z_m_ready = 1'b1;
        tick();
        chk("z_acc", z_m_valid, 1'b0);
        z_valid = 4'b0001;
        repeat (2) tick();
        z_m_done = 1'b1;
        tick();
        z_m_done = 1'b0;
        chk("z_done", z_done, 4'b0010);
        chk("z_rel", z_sync_n, 4'hF);
        chk("z_idle", z_busy, 1'b0);
        tick();
        chk("z_next_sync", z_sync_n, 4'b1110);
        chk("z_next_rdy", z_ready, 4'b0001);
        chk("z_next_dat", z_m_data, 16'h1111);
        z_valid = '0;
        tick();
        z_m_done = 1'b1;
        tick();
        z_m_done = 1'b0;
        chk("z_done2", z_done, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
